// File: rtl/pre_decode_stage_if.sv
// ============================================================================
// Module      : pre_decode_stage_if
// Description : Fetch -> pre-decode -> decode handshake, bus and redirect bundle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface pre_decode_stage_if;
    logic         FpD_valid;
    logic [74:0]  FpD_BUS;
    logic         pD_allowin;
    logic         flush_i;
    logic         D_allowin;
    logic         pDD_valid;
    logic [106:0] pDD_BUS;
    logic [32:0]  predict_BUS;

    modport master (
        output FpD_valid, FpD_BUS, flush_i, D_allowin,
        input  pD_allowin, pDD_valid, pDD_BUS, predict_BUS
    );

    modport slave (
        input  FpD_valid, FpD_BUS, flush_i, D_allowin,
        output pD_allowin, pDD_valid, pDD_BUS, predict_BUS
    );
endinterface

`default_nettype wire

// File: rtl/pre_decode_stage.sv
// ============================================================================
// Module      : pre_decode_stage
// Description : Pipeline stage between fetch and decode that statically
//               predicts direct branches and redirects fetch once per entry.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pre_decode_stage #(
    parameter bit PREDICT_EN    = 1'b1,
    parameter bit BACKWARD_ONLY = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    pre_decode_stage_if.slave pd
);

    logic        pd_valid;
    logic        predicted;
    logic [74:0] bus_q;

    logic        allowin;
    logic        capture;
    logic        predict_taken;

    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [7:0]  ecode;
    logic        esubcode;
    logic [5:0]  opc;

    logic        is_b;
    logic        is_cond;
    logic        is_branch;
    logic        cond;
    logic [31:0] offs;
    logic [31:0] target;
    logic [31:0] br_target;
    logic        pred_taken;
    logic        unused_pc_en;

    assign pc           = bus_q[74:43];
    assign inst         = bus_q[42:11];
    assign unused_pc_en = bus_q[10];
    assign ex           = bus_q[9];
    assign ecode        = bus_q[8:1];
    assign esubcode     = bus_q[0];
    assign opc          = inst[31:26];

    // The stage never stalls on its own, so it can take a new entry whenever
    // it is empty or its occupant is leaving.
    assign allowin = !pd_valid || pd.D_allowin;
    assign capture = allowin && pd.FpD_valid && !pd.flush_i;

    always_comb begin
        is_b    = (opc == 6'b010100) || (opc == 6'b010101);
        is_cond = (opc >= 6'b010110) && (opc <= 6'b011011);
        offs    = 32'd0;
        if (is_b) begin
            offs = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
        end else if (is_cond) begin
            offs = {{14{inst[25]}}, inst[25:10], 2'b00};
        end
        is_branch = is_b || is_cond;
        target    = pc + offs;
        br_target = is_branch ? target : 32'd0;
        cond      = is_b || (is_cond && (offs[31] || !BACKWARD_ONLY));
    end

    assign pred_taken    = PREDICT_EN && cond && !ex;
    assign predict_taken = pred_taken && pd_valid && !predicted && !pd.flush_i;

    assign pd.pD_allowin  = allowin;
    assign pd.pDD_valid   = pd_valid && !pd.flush_i;
    assign pd.pDD_BUS     = {pc, inst, pred_taken, br_target, ex, ecode, esubcode};
    assign pd.predict_BUS = {predict_taken, br_target};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pd_valid  <= 1'b0;
            predicted <= 1'b0;
            bus_q     <= 75'd0;
        end else begin
            if (pd.flush_i) begin
                pd_valid <= 1'b0;
            end else if (allowin) begin
                pd_valid <= pd.FpD_valid;
            end

            // A newly captured entry owns its own one-shot redirect.
            if (capture) begin
                bus_q     <= pd.FpD_BUS;
                predicted <= 1'b0;
            end else if (predict_taken) begin
                predicted <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pre_decode_stage.sv
// ============================================================================
// Module      : tb_pre_decode_stage
// Description : Table-driven, scoreboarded bench for pre_decode_stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pre_decode_stage;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    pre_decode_stage_if pif ();

    pre_decode_stage #(
        .PREDICT_EN    (1'b1),
        .BACKWARD_ONLY (1'b1)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .pd   (pif.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ex;
        logic [7:0]  ecode;
        logic        esub;
        logic        exp_taken;
        logic        exp_br;
        logic [31:0] exp_tgt;
    } vec_t;

    typedef struct {
        logic [106:0] bus;
        logic [32:0]  pred;
        logic         br;
    } exp_t;

    vec_t vecs [10];
    exp_t sb [$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [106:0] act, input logic [106:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [74:0] mk(input vec_t v);
        return {v.pc, v.inst, 1'b1, v.ex, v.ecode, v.esub};
    endfunction

    initial begin
        exp_t         e;
        logic [106:0] mask;
        int           n;

        //          pc            inst          ex    ecode  esub  taken br    target
        vecs[0] = '{32'h1c000000, 32'h02800000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h00000000}; // non-branch
        vecs[1] = '{32'h1c000010, 32'h5FFFF000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h1c000000}; // BNE back
        vecs[2] = '{32'h1c000020, 32'h58001000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h1c000030}; // BEQ fwd
        vecs[3] = '{32'h1c000100, 32'h50040000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h1c000500}; // B fwd
        vecs[4] = '{32'h1c001000, 32'h57FFFBFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h1c000FF8}; // BL back
        vecs[5] = '{32'h1c001100, 32'h4FFFF000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h00000000}; // JIRL
        vecs[6] = '{32'h1c002000, 32'h6C004000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h1c002040}; // BGEU fwd
        vecs[7] = '{32'h1c003000, 32'h63FC0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h1c002C00}; // BLT back
        vecs[8] = '{32'h1c004000, 32'h50040000, 1'b1, 8'h08, 1'b1, 1'b0, 1'b1, 32'h1c004400}; // B with ex
        vecs[9] = '{32'hFFFFFFF0, 32'h50040000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h000003F0}; // wrap

        pif.FpD_valid = 1'b0;
        pif.FpD_BUS   = '0;
        pif.flush_i   = 1'b0;
        pif.D_allowin = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pDD_valid",   {106'd0, pif.pDD_valid},   107'd0);
        chk("rst_pD_allowin",  {106'd0, pif.pD_allowin},  107'd1);
        chk("rst_predict_BUS", {74'd0, pif.predict_BUS},  107'd0);
        chk("rst_pDD_BUS",     pif.pDD_BUS,               107'd0);
        rstn = 1'b1;

        // Table vectors, one at a time with D_allowin=1
        foreach (vecs[i]) begin
            @(negedge clk);
            pif.FpD_valid = 1'b1;
            pif.FpD_BUS   = mk(vecs[i]);
            e.bus  = {vecs[i].pc, vecs[i].inst, vecs[i].exp_taken, vecs[i].exp_tgt,
                      vecs[i].ex, vecs[i].ecode, vecs[i].esub};
            e.pred = {vecs[i].exp_taken, vecs[i].exp_tgt};
            e.br   = vecs[i].exp_br;
            sb.push_back(e);

            n = 0;
            do begin
                @(negedge clk);
                pif.FpD_valid = 1'b0;
                n++;
            end while (!pif.pDD_valid && n < 4);
            chk($sformatf("v%0d_valid", i), {106'd0, pif.pDD_valid}, 107'd1);

            e    = sb.pop_front();
            mask = '1;
            if (!e.br) mask[41:10] = '0;
            chk($sformatf("v%0d_pDD_BUS", i), pif.pDD_BUS & mask, e.bus & mask);
            chk($sformatf("v%0d_predict", i), {74'd0, pif.predict_BUS}, {74'd0, e.pred});
        end
        @(negedge clk);
        chk("idle_pDD_valid", {106'd0, pif.pDD_valid}, 107'd0);

        // B under a 3-cycle decode stall, then replace with no bubble
        pif.D_allowin = 1'b0;
        pif.FpD_valid = 1'b1;
        pif.FpD_BUS   = mk(vecs[4]);
        @(negedge clk);
        pif.FpD_BUS = mk(vecs[1]);
        #1;
        chk("stall1_predict", {74'd0, pif.predict_BUS}, {74'd0, 1'b1, 32'h1c000FF8});
        chk("stall1_valid",   {106'd0, pif.pDD_valid},  107'd1);
        chk("stall1_allowin", {106'd0, pif.pD_allowin}, 107'd0);
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("stall%0d_taken", k),   {106'd0, pif.predict_BUS[32]}, 107'd0);
            chk($sformatf("stall%0d_valid", k),   {106'd0, pif.pDD_valid},       107'd1);
            chk($sformatf("stall%0d_allowin", k), {106'd0, pif.pD_allowin},      107'd0);
            chk($sformatf("stall%0d_pc", k),      {75'd0, pif.pDD_BUS[106:75]},  {75'd0, 32'h1c001000});
        end
        pif.D_allowin = 1'b1;
        @(negedge clk);
        pif.FpD_valid = 1'b0;
        #1;
        chk("replace_pc",      {75'd0, pif.pDD_BUS[106:75]}, {75'd0, 32'h1c000010});
        chk("replace_predict", {74'd0, pif.predict_BUS},     {74'd0, 1'b1, 32'h1c000000});
        chk("replace_valid",   {106'd0, pif.pDD_valid},      107'd1);

        // Flush while a backward branch is held, with a new entry offered
        @(negedge clk);
        pif.FpD_valid = 1'b1;
        pif.FpD_BUS   = mk(vecs[1]);
        @(negedge clk);
        pif.FpD_BUS = mk(vecs[3]);
        pif.flush_i = 1'b1;
        #1;
        chk("flush_valid", {106'd0, pif.pDD_valid},      107'd0);
        chk("flush_taken", {106'd0, pif.predict_BUS[32]}, 107'd0);
        @(negedge clk);
        pif.flush_i   = 1'b0;
        pif.FpD_valid = 1'b0;
        #1;
        chk("postflush_valid",   {106'd0, pif.pDD_valid},      107'd0);
        chk("postflush_allowin", {106'd0, pif.pD_allowin},     107'd1);
        chk("postflush_pc",      {75'd0, pif.pDD_BUS[106:75]}, {75'd0, 32'h1c000010});

        // Reset mid-operation drops the held branch without a redirect
        @(negedge clk);
        pif.FpD_valid = 1'b1;
        pif.FpD_BUS   = mk(vecs[1]);
        @(negedge clk);
        rstn        = 1'b0;
        pif.FpD_BUS = mk(vecs[4]);
        @(negedge clk);
        #1;
        chk("midrst_predict", {74'd0, pif.predict_BUS}, 107'd0);
        chk("midrst_valid",   {106'd0, pif.pDD_valid},  107'd0);
        chk("midrst_bus",     pif.pDD_BUS,              107'd0);
        rstn          = 1'b1;
        pif.FpD_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/pre_decode_stage.md
PRE_DECODE_STAGE -- requirements
Module: pre_decode_stage

Interface
REQ-001 Parameter PREDICT_EN, default 1; 0 forces predict_BUS[32] to 0 at all times.
REQ-002 Parameter BACKWARD_ONLY, default 1; 1 predicts conditional branches taken only when the offset is negative; 0 predicts all conditional branches taken.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 FpD_valid  input  1  fetch stage has an instruction for this stage.
REQ-006 FpD_BUS  input  75  {pc[74:43], inst[42:11], pc_en[10], ex[9], ecode[8:1], esubcode[0]}.
REQ-007 pD_allowin  output  1  this stage accepts FpD_BUS this cycle.
REQ-008 flush_i  input  1  pipeline flush (branch resolved taken, exception entry, or ertn).
REQ-009 D_allowin  input  1  decode stage accepts this stage's output.
REQ-010 pDD_valid  output  1  pDD_BUS is valid for decode.
REQ-011 pDD_BUS  output  107  {pc[106:75], inst[74:43], pred_taken[42], pred_target[41:10], ex[9], ecode[8:1], esubcode[0]}.
REQ-012 predict_BUS  output  33  {taken[32], target[31:0]} redirect to fetch.

Function
REQ-013 Stage registers: pD_valid, a 75-bit bus register, and a predicted flag.
REQ-014 pD_ready_go is constant 1; pD_allowin = !pD_valid || D_allowin.
REQ-015 Capture when pD_allowin && FpD_valid && !flush_i: load FpD_BUS, set pD_valid=1 next cycle, clear predicted.
REQ-016 When pD_allowin && !FpD_valid, pD_valid becomes 0 next cycle.
REQ-017 flush_i clears pD_valid next cycle regardless of other inputs, and it has priority over capture.
REQ-018 pDD_valid = pD_valid && !flush_i, combinational.
REQ-019 Decode fields from the held instruction (opc = inst[31:26]):
- B = 010100, BL = 010101: offs = sext({inst[9:0], inst[25:10], 2'b00}).
- BEQ, BNE, BLT, BGE, BLTU, BGEU = 010110..011011: offs = sext({inst[25:10], 2'b00}).
- JIRL and all other opcodes are never predicted.
REQ-020 target = pc + offs, in 32-bit modulo arithmetic; wrap-around is ignored.
REQ-021 Prediction condition (cond) is true for B/BL always, and for conditional branches when offs[31]=1 or BACKWARD_ONLY=0.
REQ-022 predict_BUS[32] = PREDICT_EN && pD_valid && !predicted && !ex && !flush_i && cond.
REQ-023 predict_BUS[31:0] = target whenever the held instruction is a branch, and 0 otherwise.
REQ-024 predicted is set to 1 on the edge after predict_BUS[32]=1, so the redirect pulses exactly once per held instruction, even under D_allowin stall.
REQ-025 pDD_BUS pred_taken = PREDICT_EN && cond && !ex (stable through stalls); pred_target = target.
REQ-026 The ex, ecode and esubcode fields pass through unchanged.
REQ-027 An instruction with ex=1 is forwarded but never predicted.
REQ-028 Simultaneous leave and capture (pD_valid && D_allowin && FpD_valid) replaces the entry in one cycle with no bubble, and predicted is cleared.
REQ-029 Latency: FpD_BUS accepted at edge N appears on pDD_BUS, with its prediction on predict_BUS, in cycle N+1.

Reset
REQ-030 While rstn=0 at an edge: pD_valid=0, predicted=0, bus register=0.
REQ-031 Output values during and after reset:
- pDD_valid=0, pD_allowin=1, predict_BUS=33'b0.
- pDD_BUS = all zeros except pred_taken, which follows REQ-025 for inst=0.
REQ-032 Reset mid-operation discards the held instruction with no predict pulse in the following cycle.

Verification
REQ-033 Straight-line: pc 0x1c000000, inst 0x02800000 (non-branch), D_allowin=1 -> pDD_valid=1 next cycle; predict_BUS=0; pred_taken=0.
REQ-034 Backward BNE: pc 0x1c000010, offs16 = 0xFFFC -> predict_BUS = {1, 0x1c000000} for one cycle; pDD_BUS pred_target = 0x1c000000.
REQ-035 Forward BEQ, BACKWARD_ONLY=1: offs16 = 0x0004 -> predict_BUS[32]=0 and pred_taken=0, but predict_BUS[31:0] = pc+16.
REQ-036 B under 3-cycle D_allowin=0 stall: taken pulse only in the first cycle; pDD_valid held at 1; pD_allowin=0 during the stall.
REQ-037 flush_i in the same cycle as a captured backward branch -> pDD_valid=0 and predict_BUS[32]=0 that cycle; pD_valid=0 next cycle; the new FpD_BUS is not captured.
REQ-038 Instruction with ex=1, ecode 0x08, opcode B -> forwarded with ex/ecode intact; predict_BUS[32]=0; pred_taken=0.
